// File: rtl/seq_det_pkg.sv
// +------------------------------------------------------------------+
// | Module   : seq_det_pkg                                            |
// | Brief    : Shared types and constants for seq_detector_prog.      |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
`default_nettype none

package seq_det_pkg;

  localparam int MIN_LEN = 2;
  // Widest legal pattern; the stored config is sized for it.
  localparam int PAT_W   = 32;
  localparam int PLEN_W  = 6;
  localparam int CNT_W_DEFAULT = 8;
  localparam int CNT_MAX       = (1 << CNT_W_DEFAULT) - 1;

  typedef struct packed {
    logic [PAT_W-1:0]  pattern;
    logic [PLEN_W-1:0] len;
    logic              overlap;
  } cfg_t;

  function automatic int len_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_detector_prog_if.sv
// +------------------------------------------------------------------+
// | Module   : seq_detector_prog_if                                   |
// | Brief    : Config, serial input and status bundle of the detector.|
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
`default_nettype none

interface seq_detector_prog_if
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = len_w(MAX_LEN),
  parameter int CNT_W   = 8
);

  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               in_valid;
  logic               in_bit;
  logic               match;
  logic               match_q;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;
  logic               active;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_bit,
    input  match, match_q, match_count, cfg_err, active
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_bit,
    output match, match_q, match_count, cfg_err, active
  );

endinterface

`default_nettype wire

// File: rtl/seq_detector_prog_sat_counter.sv
// +------------------------------------------------------------------+
// | Module   : sat_counter                                            |
// | Brief    : Up counter with clear that sticks at all-ones.         |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (inc && (r_count != c_cnt_max)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/seq_detector_prog.sv
// +------------------------------------------------------------------+
// | Module   : seq_detector_prog                                      |
// | Brief    : Runtime-programmable serial pattern detector.          |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
`default_nettype none

module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = len_w(MAX_LEN),
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  seq_detector_prog_if.slave bus
);

  localparam logic [LEN_W-1:0] c_fill_max = LEN_W'(MAX_LEN);

  cfg_t               r_cfg;
  // The oldest history bit never reaches the compare window, so it is not kept.
  logic [MAX_LEN-2:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_active;
  logic               r_cfg_err;
  logic               r_match_q;

  logic [MAX_LEN-1:0] w_cand;
  logic [PAT_W-1:0]   w_mask;
  logic [PAT_W-1:0]   w_diff;
  logic               w_filled;
  logic               w_sample;
  logic               w_match;
  logic               w_legal;

  assign w_cand   = {r_hist, bus.in_bit};
  assign w_mask   = ~({PAT_W{1'b1}} << r_cfg.len);
  assign w_diff   = (PAT_W'(w_cand) ^ r_cfg.pattern) & w_mask;
  assign w_filled = (32'(r_fill) + 32'd1) >= 32'(r_cfg.len);
  assign w_sample = r_active & bus.in_valid & ~bus.cfg_load;
  assign w_match  = w_sample & w_filled & (w_diff == '0);
  assign w_legal  = (32'(bus.cfg_len) >= 32'(MIN_LEN)) &&
                    (32'(bus.cfg_len) <= 32'(MAX_LEN));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg     <= '0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_active  <= 1'b0;
      r_cfg_err <= 1'b0;
      r_match_q <= 1'b0;
    end else if (bus.cfg_load) begin
      r_cfg.pattern <= PAT_W'(bus.cfg_pattern);
      r_cfg.len     <= PLEN_W'(bus.cfg_len);
      r_cfg.overlap <= bus.cfg_overlap;
      r_active      <= w_legal;
      r_cfg_err     <= ~w_legal;
      r_hist        <= '0;
      r_fill        <= '0;
      r_match_q     <= 1'b0;
    end else begin
      r_match_q <= w_match;
      if (w_sample) begin
        r_hist <= w_cand[MAX_LEN-2:0];
        // Non-overlapping mode demands a full set of fresh bits after a hit.
        if (w_match && !r_cfg.overlap) begin
          r_fill <= '0;
        end else if (r_fill != c_fill_max) begin
          r_fill <= r_fill + LEN_W'(1);
        end
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.cfg_load),
    .inc   (w_match),
    .count (bus.match_count)
  );

  assign bus.match   = w_match;
  assign bus.match_q = r_match_q;
  assign bus.cfg_err = r_cfg_err;
  assign bus.active  = r_active;

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_prog.sv
// +------------------------------------------------------------------+
// | Module   : tb_seq_detector_prog                                   |
// | Brief    : Self-checking bench; two detectors (8- and 2-bit count)|
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
`default_nettype none

module tb_seq_detector_prog;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_detector_prog_if #(.MAX_LEN(8), .CNT_W(8)) if8 ();
  seq_detector_prog_if #(.MAX_LEN(8), .CNT_W(2)) if2 ();

  seq_detector_prog #(.MAX_LEN(8), .CNT_W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  seq_detector_prog #(.MAX_LEN(8), .CNT_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        exp_q[$];
  logic        prev_exp = 1'b0;
  logic        e;
  logic [15:0] s, v, x;
  int          n;

  task automatic put_bit(input logic load, input logic vld, input logic b);
    if8.cfg_load = load; if8.in_valid = vld; if8.in_bit = b;
    if2.cfg_load = load; if2.in_valid = vld; if2.in_bit = b;
  endtask

  task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                          input logic vld, input logic b);
    @(negedge clk);
    if8.cfg_pattern = pat; if8.cfg_len = len; if8.cfg_overlap = ov;
    if2.cfg_pattern = pat; if2.cfg_len = len; if2.cfg_overlap = ov;
    put_bit(1'b1, vld, b);
    prev_exp = 1'b0;
    #1;
  endtask

  // Drive one cycle at the falling edge and queue the expected Mealy output.
  task automatic drive_bit(input logic vld, input logic b, input logic exp_m);
    @(negedge clk);
    put_bit(1'b0, vld, b);
    exp_q.push_back(exp_m);
    #1;
  endtask

  task automatic test_reset();
    put_bit(1'b0, 1'b0, 1'b0);
    if8.cfg_pattern = '0; if8.cfg_len = '0; if8.cfg_overlap = 1'b0;
    if2.cfg_pattern = '0; if2.cfg_len = '0; if2.cfg_overlap = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    put_bit(1'b0, 1'b1, 1'b1);
    #1;
    n_cmp++; if (if8.match !== 1'b0)       begin n_bad++; $display("FAIL rst_match: got %b expected 0", if8.match); end
    n_cmp++; if (if8.match_q !== 1'b0)     begin n_bad++; $display("FAIL rst_match_q: got %b expected 0", if8.match_q); end
    n_cmp++; if (if8.match_count !== 8'd0) begin n_bad++; $display("FAIL rst_count: got %0d expected 0", if8.match_count); end
    n_cmp++; if (if8.cfg_err !== 1'b0)     begin n_bad++; $display("FAIL rst_cfg_err: got %b expected 0", if8.cfg_err); end
    n_cmp++; if (if8.active !== 1'b0)      begin n_bad++; $display("FAIL rst_active: got %b expected 0", if8.active); end
  endtask

  task automatic test_overlap();
    load_cfg(8'b0001_0011, 4'd5, 1'b1, 1'b0, 1'b0);
    s = 16'b100110011; x = 16'b000010001; v = '1; n = 9;
    for (int i = n - 1; i >= 0; i--) begin
      drive_bit(v[i], s[i], x[i]);
      e = exp_q.pop_front();
      n_cmp++; if (if8.match !== e)          begin n_bad++; $display("FAIL ovl_match bit %0d: got %b expected %b", n - i, if8.match, e); end
      n_cmp++; if (if8.match_q !== prev_exp) begin n_bad++; $display("FAIL ovl_match_q bit %0d: got %b expected %b", n - i, if8.match_q, prev_exp); end
      prev_exp = e;
    end
    drive_bit(1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front();
    n_cmp++; if (if8.match_q !== prev_exp) begin n_bad++; $display("FAIL ovl_last_match_q: got %b expected %b", if8.match_q, prev_exp); end
    prev_exp = e;
    n_cmp++; if (if8.match_count !== 8'd2) begin n_bad++; $display("FAIL ovl_count: got %0d expected 2", if8.match_count); end
    n_cmp++; if (if8.active !== 1'b1)      begin n_bad++; $display("FAIL ovl_active: got %b expected 1", if8.active); end
  endtask

  task automatic test_non_overlap();
    load_cfg(8'b0001_0011, 4'd5, 1'b0, 1'b0, 1'b0);
    s = 16'b100110011; x = 16'b000010000; v = '1; n = 9;
    for (int i = n - 1; i >= 0; i--) begin
      drive_bit(v[i], s[i], x[i]);
      e = exp_q.pop_front();
      n_cmp++; if (if8.match !== e)          begin n_bad++; $display("FAIL novl_match bit %0d: got %b expected %b", n - i, if8.match, e); end
      n_cmp++; if (if8.match_q !== prev_exp) begin n_bad++; $display("FAIL novl_match_q bit %0d: got %b expected %b", n - i, if8.match_q, prev_exp); end
      prev_exp = e;
    end
    drive_bit(1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front();
    prev_exp = e;
    n_cmp++; if (if8.match_count !== 8'd1) begin n_bad++; $display("FAIL novl_count: got %0d expected 1", if8.match_count); end
  endtask

  task automatic test_ones();
    for (int m = 1; m >= 0; m--) begin
      load_cfg(8'b0000_1111, 4'd4, m[0], 1'b0, 1'b0);
      s = 16'b111111; v = '1; n = 6;
      x = (m == 1) ? 16'b000111 : 16'b000100;
      for (int i = n - 1; i >= 0; i--) begin
        drive_bit(v[i], s[i], x[i]);
        e = exp_q.pop_front();
        n_cmp++; if (if8.match !== e)          begin n_bad++; $display("FAIL ones%0d_match bit %0d: got %b expected %b", m, n - i, if8.match, e); end
        n_cmp++; if (if8.match_q !== prev_exp) begin n_bad++; $display("FAIL ones%0d_match_q bit %0d: got %b expected %b", m, n - i, if8.match_q, prev_exp); end
        prev_exp = e;
      end
      drive_bit(1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      prev_exp = e;
      n_cmp++;
      if (if8.match_count !== ((m == 1) ? 8'd3 : 8'd1)) begin
        n_bad++; $display("FAIL ones%0d_count: got %0d expected %0d", m, if8.match_count, (m == 1) ? 3 : 1);
      end
    end
  endtask

  task automatic test_gap();
    load_cfg(8'b0001_0011, 4'd5, 1'b1, 1'b0, 1'b0);
    s = 16'b10011111; v = 16'b11100011; x = 16'b00000001; n = 8;
    for (int i = n - 1; i >= 0; i--) begin
      drive_bit(v[i], s[i], x[i]);
      e = exp_q.pop_front();
      n_cmp++; if (if8.match !== e)          begin n_bad++; $display("FAIL gap_match cyc %0d: got %b expected %b", n - i, if8.match, e); end
      n_cmp++; if (if8.match_q !== prev_exp) begin n_bad++; $display("FAIL gap_match_q cyc %0d: got %b expected %b", n - i, if8.match_q, prev_exp); end
      prev_exp = e;
    end
    drive_bit(1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front();
    prev_exp = e;
    n_cmp++; if (if8.match_count !== 8'd1) begin n_bad++; $display("FAIL gap_count: got %0d expected 1", if8.match_count); end
  endtask

  task automatic test_illegal();
    load_cfg(8'b0000_0001, 4'd1, 1'b1, 1'b0, 1'b0);
    s = 16'b1111; v = '1; x = '0; n = 4;
    for (int i = n - 1; i >= 0; i--) begin
      drive_bit(v[i], s[i], x[i]);
      e = exp_q.pop_front();
      n_cmp++; if (if8.match !== e) begin n_bad++; $display("FAIL len1_match bit %0d: got %b expected %b", n - i, if8.match, e); end
      prev_exp = e;
    end
    n_cmp++; if (if8.cfg_err !== 1'b1) begin n_bad++; $display("FAIL len1_cfg_err: got %b expected 1", if8.cfg_err); end
    n_cmp++; if (if8.active !== 1'b0)  begin n_bad++; $display("FAIL len1_active: got %b expected 0", if8.active); end
    n_cmp++; if (if8.match_count !== 8'd0) begin n_bad++; $display("FAIL len1_count: got %0d expected 0", if8.match_count); end

    load_cfg(8'hFF, 4'd9, 1'b1, 1'b0, 1'b0);
    drive_bit(1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front();
    prev_exp = e;
    n_cmp++; if (if8.cfg_err !== 1'b1) begin n_bad++; $display("FAIL len9_cfg_err: got %b expected 1", if8.cfg_err); end

    load_cfg(8'hA5, 4'd8, 1'b1, 1'b0, 1'b0);
    s = 16'b10100101; v = '1; x = 16'b00000001; n = 8;
    for (int i = n - 1; i >= 0; i--) begin
      drive_bit(v[i], s[i], x[i]);
      e = exp_q.pop_front();
      n_cmp++; if (if8.match !== e)          begin n_bad++; $display("FAIL len8_match bit %0d: got %b expected %b", n - i, if8.match, e); end
      n_cmp++; if (if8.match_q !== prev_exp) begin n_bad++; $display("FAIL len8_match_q bit %0d: got %b expected %b", n - i, if8.match_q, prev_exp); end
      prev_exp = e;
    end
    n_cmp++; if (if8.cfg_err !== 1'b0) begin n_bad++; $display("FAIL len8_cfg_err: got %b expected 0", if8.cfg_err); end
    n_cmp++; if (if8.active !== 1'b1)  begin n_bad++; $display("FAIL len8_active: got %b expected 1", if8.active); end

    // A bit presented with cfg_load must be dropped: 1 + 0011 would otherwise hit 10011.
    load_cfg(8'b0001_0011, 4'd5, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (if8.match !== 1'b0) begin n_bad++; $display("FAIL load_valid_match: got %b expected 0", if8.match); end
    s = 16'b0011; v = '1; x = '0; n = 4;
    for (int i = n - 1; i >= 0; i--) begin
      drive_bit(v[i], s[i], x[i]);
      e = exp_q.pop_front();
      n_cmp++; if (if8.match !== e) begin n_bad++; $display("FAIL load_valid_stream bit %0d: got %b expected %b", n - i, if8.match, e); end
      prev_exp = e;
    end
    drive_bit(1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front();
    prev_exp = e;
    n_cmp++; if (if8.match_count !== 8'd0) begin n_bad++; $display("FAIL load_valid_count: got %0d expected 0", if8.match_count); end
  endtask

  task automatic test_saturate_and_reset();
    load_cfg(8'b0000_0011, 4'd2, 1'b1, 1'b0, 1'b0);
    s = 16'b111111; v = '1; x = 16'b011111; n = 6;
    for (int i = n - 1; i >= 0; i--) begin
      drive_bit(v[i], s[i], x[i]);
      e = exp_q.pop_front();
      n_cmp++; if (if2.match !== e)          begin n_bad++; $display("FAIL sat_match bit %0d: got %b expected %b", n - i, if2.match, e); end
      n_cmp++; if (if2.match_q !== prev_exp) begin n_bad++; $display("FAIL sat_match_q bit %0d: got %b expected %b", n - i, if2.match_q, prev_exp); end
      prev_exp = e;
    end
    drive_bit(1'b1, 1'b1, 1'b1);
    e = exp_q.pop_front();
    n_cmp++; if (if2.match !== e) begin n_bad++; $display("FAIL sat_pre_rst_match: got %b expected %b", if2.match, e); end
    n_cmp++; if (if2.match_count !== 2'd3) begin n_bad++; $display("FAIL sat_count2: got %0d expected 3", if2.match_count); end
    n_cmp++; if (if8.match_count !== 8'd5) begin n_bad++; $display("FAIL sat_count8: got %0d expected 5", if8.match_count); end

    @(negedge clk);
    rst = 1'b1;
    put_bit(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    put_bit(1'b0, 1'b1, 1'b1);
    exp_q.push_back(1'b0);
    prev_exp = 1'b0;
    #1;
    e = exp_q.pop_front();
    n_cmp++; if (if2.match !== e)          begin n_bad++; $display("FAIL post_rst_match: got %b expected %b", if2.match, e); end
    n_cmp++; if (if2.match_q !== prev_exp) begin n_bad++; $display("FAIL post_rst_match_q: got %b expected 0", if2.match_q); end
    n_cmp++; if (if2.match_count !== 2'd0) begin n_bad++; $display("FAIL post_rst_count: got %0d expected 0", if2.match_count); end
    n_cmp++; if (if2.active !== 1'b0)      begin n_bad++; $display("FAIL post_rst_active: got %b expected 0", if2.active); end
    n_cmp++; if (if2.cfg_err !== 1'b0)     begin n_bad++; $display("FAIL post_rst_cfg_err: got %b expected 0", if2.cfg_err); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_ones();
    test_gap();
    test_illegal();
    test_saturate_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
Runtime-programmable serial bit-pattern detector. It generalises the fixed 5-bit Mealy sequence detectors in the serial-protocol test blocks. Pattern, pattern length and overlap mode are loaded through a config port. It provides a Mealy match pulse, a registered (Moore-timed) match flag and a saturating match counter, and sits between a serial input stage and the status/debug register block.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (legal 2..32)
LEN_W, $clog2(MAX_LEN)+1, width of the length field
CNT_W, 8, width of the match counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
cfg_load  in  1  single-cycle strobe; captures the cfg_* inputs
cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit [0] the last
cfg_len  in  LEN_W  pattern length in bits
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
in_valid  in  1  in_bit is sampled this cycle
in_bit  in  1  serial data bit
match  out  1  Mealy pulse, combinational, same cycle as the completing bit
match_q  out  1  match registered; high exactly one cycle after match
match_count  out  CNT_W  number of matches since the last reset or cfg_load; saturates at all-ones
cfg_err  out  1  loaded length is illegal; detector is disabled
active  out  1  a legal configuration is loaded

Behaviour:
- Reset (synchronous, rst=1 at the clock edge):
  - hist=0, fill=0, pattern/len/overlap registers=0, match_q=0, match_count=0, cfg_err=0, active=0.
  - match is forced 0 while active=0, so match=0 out of reset.
- Config:
  - On cfg_load, capture pattern, len and overlap, and clear hist, fill, match_q and match_count next cycle.
  - Legal length is 2 <= cfg_len <= MAX_LEN. Legal: active=1, cfg_err=0. Illegal: active=0, cfg_err=1.
  - cfg_load in the same cycle as in_valid: config wins; in_bit is discarded and match=0 that cycle.
  - rst has priority over cfg_load.
- State:
  - hist[MAX_LEN-1:0] is a shift register holding the most recent bits.
  - fill (0..MAX_LEN) is the count of valid history bits; it saturates at MAX_LEN.
- Candidate window: cand = {hist[MAX_LEN-2:0], in_bit}.
- Match condition: match = active & in_valid & (fill >= len-1) & (cand[len-1:0] == pattern[len-1:0]). Bits above len are ignored.
- Sampled cycle (in_valid=1, active=1, no cfg_load):
  - hist <= cand.
  - Overlap mode, or no match: fill <= min(fill+1, MAX_LEN).
  - Non-overlap mode and match: fill <= 0. The next match needs len fresh bits.
- in_valid=0: hist, fill and count hold; match=0. Gaps are transparent to the pattern.
- match_q <= match every cycle.
- match_count increments on match and saturates at 2^CNT_W-1 with no wrap.
- The behaviour is equivalent to a KMP state machine. The shift/compare form is mandated for parameter scalability.
- Latency: match has 0 cycles from the completing bit; match_q and match_count update 1 cycle later.
- Reset mid-stream discards the partial history. No match may be produced from bits sampled before the reset.

Decomposition:
- Package seq_det_pkg holds:
  - the LEN_W derivation function;
  - constants MIN_LEN=2 and the saturating count max;
  - a cfg struct typedef {pattern, len, overlap}.
- Sub-module sat_counter (CNT_W, inc, clr) implements the saturating match counter.
- All other logic stays flat in seq_detector_prog.

Test Plan:
1. Overlap, pattern 10011, len 5, with stream 1,0,0,1,1,0,0,1,1 -> match on bits 5 and 9, match_q on the following cycles, match_count=2.
2. Same pattern and stream with cfg_overlap=0 -> match on bit 5 only, match_count=1.
3. Pattern 1111, len 4, with stream 111111 -> overlap: matches on bits 4, 5, 6 and count=3. Non-overlap: match on bit 4 only and count=1.
4. Pattern 10011 overlap, stream 1,0,0,1,1 with in_valid low for 3 cycles between bits 3 and 4 -> one match on bit 5; match=0 during the gap cycles.
5. Illegal length cases:
   - cfg_len=1 -> cfg_err=1, active=0, and no match on any stream.
   - Reload with cfg_len=MAX_LEN=8, pattern 0xA5, stream 10100101 -> cfg_err=0 and match on bit 8.
   - cfg_load asserted together with in_valid=1 -> that bit is ignored.
6. CNT_W=2 with pattern 11 overlap and six 1s -> 5 matches, match_count saturates at 3. Then assert rst mid-stream with stream 1 (rst) 1 -> no match on the bit after reset, and all outputs are 0.
